// File: rtl/alu_result_stage.sv
// alu_result_stage: two-entry registered ALU output stage with valid/ready handshake and status-flags register
module alu_result_stage #(
    parameter int N = 4,
    parameter int R = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_result,
    input  logic [1:0]   in_flags,
    input  logic [3:0]   in_select,
    input  logic [R-1:0] in_rd,
    input  logic         in_wr_en,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [R-1:0] out_rd,
    output logic         out_wr_en,
    output logic [1:0]   status_flags,
    output logic         illegal_op
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    typedef struct packed {
        logic [N-1:0] result;
        logic [1:0]   flags;
        logic [R-1:0] rd;
        logic         wr_en;
        logic         flags_we;
    } entry_t;
    state_t state;
    entry_t head, skid, incoming;
    logic accept, retire;
    // Handshake events and the filtered form of the incoming entry
    always_comb begin
        accept            = in_valid & in_ready & ~flush;
        retire            = out_valid & out_ready;
        incoming.result   = in_result;
        incoming.flags    = in_flags;
        incoming.rd       = in_rd;
        incoming.wr_en    = in_wr_en & (in_select != 4'd1) & (in_select < 4'd12);
        incoming.flags_we = (in_select >= 4'd1) & (in_select <= 4'd3);
    end
    assign out_result = head.result;
    assign out_rd     = head.rd;
    assign out_wr_en  = head.wr_en;
    // Occupancy FSM with registered handshake outputs, entry storage and architectural flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= EMPTY;
            out_valid    <= 1'b0;
            in_ready     <= 1'b1;
            head         <= '0;
            skid         <= '0;
            status_flags <= 2'b00;
            illegal_op   <= 1'b0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            if (accept && in_select >= 4'd12)
                illegal_op <= 1'b1;
            if (retire && head.flags_we)
                status_flags <= head.flags;
            case (state)
                EMPTY: if (accept) begin
                    head      <= incoming;
                    state     <= ONE;
                    out_valid <= 1'b1;
                end
                ONE: begin
                    if (accept && retire)
                        head <= incoming;
                    else if (accept) begin
                        skid     <= incoming;
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (retire) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: if (retire) begin
                    head     <= skid;
                    state    <= ONE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule
